// File: rtl/sfifo_pkg.sv
// sfifo_pkg: shared constants and sizing helpers for the synchronous FIFO.
//   SFIFO_STD / SFIFO_FWFT : read-mode selectors for the FWFT parameter
//   sfifo_cnt_w()          : width of an occupancy counter holding 0..depth
//   sfifo_ptr_w()          : width of a pointer addressing 0..depth-1
package sfifo_pkg;

   localparam int unsigned SFIFO_STD  = 0;
   localparam int unsigned SFIFO_FWFT = 1;

   function automatic int unsigned sfifo_cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned sfifo_ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sfifo_ram.sv
// sfifo_ram: FIFO storage array, one synchronous write port, one asynchronous
// read port, no reset (contents survive a FIFO reset).
//   clk     : write clock
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rd_data : read data, combinational from raddr
module sfifo_ram
   import sfifo_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          we,
   input  logic [sfifo_ptr_w(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]              wdata,
   input  logic [sfifo_ptr_w(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]              rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Asynchronous read port
   assign rd_data = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with occupancy count, full/empty and
// programmable almost-full/almost-empty flags, standard or FWFT read mode.
// Optional macro SFIFO_ERR_FLAGS_EN adds sticky overflow/underflow ports.
//   clk, rst      : clock, asynchronous active-high reset
//   w_en, data_in : write request and data (dropped while full)
//   r_en          : read request (ignored while empty)
//   data_out      : read data (registered when FWFT=0, head entry when FWFT=1)
//   full, empty, almost_full, almost_empty : status flags
//   count         : current occupancy
//   overflow, underflow : sticky error flags (SFIFO_ERR_FLAGS_EN only)
module param_sync_fifo
   import sfifo_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AF_THRESH = DEPTH - 1,
   parameter int unsigned AE_THRESH = 1,
   parameter int unsigned FWFT      = SFIFO_STD
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          w_en,
   input  logic [WIDTH-1:0]              data_in,
   input  logic                          r_en,
   output logic [WIDTH-1:0]              data_out,
   output logic                          full,
   output logic                          empty,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [sfifo_cnt_w(DEPTH)-1:0] count
`ifdef SFIFO_ERR_FLAGS_EN
   ,
   output logic                          overflow,
   output logic                          underflow
`endif
);

   localparam int unsigned CW = sfifo_cnt_w(DEPTH);
   localparam int unsigned PW = sfifo_ptr_w(DEPTH);

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_nxt;
   logic [WIDTH-1:0] ram_rdata;
   logic             wr_acc;
   logic             rd_acc;

   // Acceptance: full blocks writes, empty blocks reads
   assign wr_acc = w_en & ~full;
   assign rd_acc = r_en & ~empty;

   // Next occupancy; simultaneous accepted read and write cancel out
   always_comb begin
      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Pointers, count and flags; flags are registered from next count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         if (wr_acc) begin
            wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         end
         count        <= count_nxt;
         full         <= (count_nxt == CW'(DEPTH));
         empty        <= (count_nxt == '0);
         almost_full  <= (count_nxt >= CW'(AF_THRESH));
         almost_empty <= (count_nxt <= CW'(AE_THRESH));
      end
   end

   sfifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk     (clk),
      .we      (wr_acc),
      .waddr   (wr_ptr),
      .wdata   (data_in),
      .raddr   (rd_ptr),
      .rd_data (ram_rdata)
   );

   // Read data path
   if (FWFT == SFIFO_FWFT) begin : g_fwft
      // Head entry shown directly; forced to zero while empty
      assign data_out = empty ? '0 : ram_rdata;
   end else begin : g_std
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_out <= '0;
         end else if (rd_acc) begin
            data_out <= ram_rdata;
         end
      end
   end

`ifdef SFIFO_ERR_FLAGS_EN
   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= overflow  | (w_en & full);
         underflow <= underflow | (r_en & empty);
      end
   end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: self-checking bench for param_sync_fifo (DEPTH=6,
// WIDTH=8), one standard-mode and one FWFT instance sharing the same stimulus.
module tb_param_sync_fifo;

   localparam int unsigned DEPTH = 6;
   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             w_en;
   logic             r_en;
   logic [WIDTH-1:0] data_in;

   logic [WIDTH-1:0] dout_s, dout_f;
   logic             full_s, empty_s, af_s, ae_s;
   logic             full_f, empty_f, af_f, ae_f;
   logic [2:0]       count_s, count_f;
`ifdef SFIFO_ERR_FLAGS_EN
   logic             ovf_s, udf_s, ovf_f, udf_f;
`endif

   param_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(dout_s), .full(full_s), .empty(empty_s),
      .almost_full(af_s), .almost_empty(ae_s), .count(count_s)
`ifdef SFIFO_ERR_FLAGS_EN
      , .overflow(ovf_s), .underflow(udf_s)
`endif
   );

   param_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
      .data_out(dout_f), .full(full_f), .empty(empty_f),
      .almost_full(af_f), .almost_empty(ae_f), .count(count_f)
`ifdef SFIFO_ERR_FLAGS_EN
      , .overflow(ovf_f), .underflow(udf_f)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          w;
      bit          r;
      logic [7:0]  d;
      int unsigned cnt;
      bit          fl;
      bit          em;
      bit          af;
      bit          ae;
   } vec_t;

   vec_t       vecs[14];
   logic [7:0] model_q[$];   // reference FIFO contents
   logic [7:0] exp_q[$];     // scoreboard: words owed by the standard instance
   logic [7:0] exp_dout;
   bit         exp_ovf;
   bit         exp_udf;
   int         pass_cnt;
   int         total_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; model decides acceptance from pre-edge occupancy
   task automatic step(input bit w, input logic [7:0] d, input bit r);
      bit          wacc;
      bit          racc;
      int unsigned sz;
      w_en    = w;
      r_en    = r;
      data_in = d;
      wacc = w && (model_q.size() < DEPTH);
      racc = r && (model_q.size() != 0);
      if (racc) exp_q.push_back(model_q.pop_front());
      if (wacc) model_q.push_back(d);
      if (w && !wacc) exp_ovf = 1'b1;
      if (r && !racc) exp_udf = 1'b1;
      @(posedge clk);
      #1;
      w_en = 1'b0;
      r_en = 1'b0;
      if (racc) exp_dout = exp_q.pop_front();
      sz = model_q.size();
      check("std_data_out", dout_s, exp_dout);
      check("std_count", count_s, sz);
      check("std_full", full_s, sz == DEPTH);
      check("std_empty", empty_s, sz == 0);
      check("std_almost_full", af_s, sz >= DEPTH - 1);
      check("std_almost_empty", ae_s, sz <= 1);
      check("fwft_count", count_f, sz);
      check("fwft_empty", empty_f, sz == 0);
      check("fwft_data_out", dout_f, (sz != 0) ? model_q[0] : 8'h00);
`ifdef SFIFO_ERR_FLAGS_EN
      check("overflow", ovf_s, exp_ovf);
      check("underflow", udf_s, exp_udf);
      check("fwft_overflow", ovf_f, exp_ovf);
      check("fwft_underflow", udf_f, exp_udf);
`endif
   endtask

   task automatic check_reset_state();
      check("rst_count", count_s, 0);
      check("rst_empty", empty_s, 1);
      check("rst_full", full_s, 0);
      check("rst_almost_full", af_s, 0);
      check("rst_almost_empty", ae_s, 1);
      check("rst_std_data_out", dout_s, 0);
      check("rst_fwft_data_out", dout_f, 0);
      check("rst_fwft_empty", empty_f, 1);
`ifdef SFIFO_ERR_FLAGS_EN
      check("rst_overflow", ovf_s, 0);
      check("rst_underflow", udf_s, 0);
`endif
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      exp_dout  = 8'h00;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
      rst       = 1'b1;
      w_en      = 1'b0;
      r_en      = 1'b0;
      data_in   = 8'h00;

      // Fill, overflow attempt, drain, underflow attempt (w, r, d, cnt, fl, em, af, ae)
      vecs[0]  = '{1'b1, 1'b0, 8'h01, 1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 1'b0, 8'h02, 2, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 8'h03, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 8'h04, 4, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 8'h05, 5, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 8'h06, 6, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 8'hAA, 6, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 8'h00, 5, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 8'h00, 4, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1};

      // Reset state while reset is held
      #12;
      check_reset_state();
      rst = 1'b0;

      // Table-driven fill/drain with overflow and underflow attempts
      foreach (vecs[i]) begin
         step(vecs[i].w, vecs[i].d, vecs[i].r);
         check("vec_count", count_s, vecs[i].cnt);
         check("vec_full", full_s, vecs[i].fl);
         check("vec_empty", empty_s, vecs[i].em);
         check("vec_almost_full", af_s, vecs[i].af);
         check("vec_almost_empty", ae_s, vecs[i].ae);
      end
      check("underflow_hold_data_out", dout_s, 8'h06);

      // Simultaneous read/write at count 3
      step(1'b1, 8'h10, 1'b0);
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h12, 1'b0);
      step(1'b1, 8'h13, 1'b1);
      check("rw_mid_count", count_s, 3);
      check("rw_mid_data", dout_s, 8'h10);
      step(1'b1, 8'h14, 1'b1);
      check("rw_mid_count2", count_s, 3);
      check("rw_mid_data2", dout_s, 8'h11);

      // Simultaneous read/write at full: write dropped
      step(1'b1, 8'h15, 1'b0);
      step(1'b1, 8'h16, 1'b0);
      step(1'b1, 8'h17, 1'b0);
      check("fill_full", full_s, 1);
      step(1'b1, 8'hEE, 1'b1);
      check("rw_full_count", count_s, 5);
      check("rw_full_data", dout_s, 8'h12);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
      check("rw_full_last", dout_s, 8'h17);

      // Simultaneous read/write at empty: read ignored
      step(1'b1, 8'h21, 1'b1);
      check("rw_empty_count", count_s, 1);
      check("rw_empty_hold", dout_s, 8'h17);
      step(1'b0, 8'h00, 1'b1);
      check("rw_empty_data", dout_s, 8'h21);

      // Wrap stream of 20 words at steady occupancy 3
      for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0);
      for (int i = 3; i < 20; i++) step(1'b1, 8'(i), 1'b1);
      check("wrap_count", count_s, 3);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
      check("wrap_last", dout_s, 8'h13);
      check("wrap_empty", empty_s, 1);

      // FWFT: first write visible next cycle without a read
      step(1'b1, 8'h5C, 1'b0);
      check("fwft_first_empty", empty_f, 0);
      check("fwft_first_data", dout_f, 8'h5C);
      step(1'b0, 8'h00, 1'b1);
      check("fwft_after_read_empty", empty_f, 1);

      // Asynchronous reset between edges with count 4
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
      check("pre_reset_count", count_s, 4);
      #2;
      rst = 1'b1;
      #1;
      check_reset_state();
      #1;
      rst = 1'b0;
      model_q.delete();
      exp_q.delete();
      exp_dout = 8'h00;
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;
      step(1'b1, 8'h77, 1'b0);
      check("post_reset_count", count_s, 1);
      check("post_reset_fwft_head", dout_f, 8'h77);
      step(1'b0, 8'h00, 1'b1);
      check("post_reset_data", dout_s, 8'h77);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, at least 1.
REQ-002 Parameter DEPTH, default 8: entries, at least 2; need not be a power of two.
REQ-003 Parameter AF_THRESH, default DEPTH-1: almost_full asserts when count >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 1: almost_empty asserts when count <= AE_THRESH.
REQ-005 Parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through.
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port w_en, input, 1: write request.
REQ-009 Port data_in, input, WIDTH: write data.
REQ-010 Port r_en, input, 1: read request.
REQ-011 Port data_out, output, WIDTH: read data.
REQ-012 Ports full, empty, almost_full, almost_empty: outputs, 1 bit each, status flags.
REQ-013 Port count, output, $clog2(DEPTH+1): current occupancy.

Function
REQ-014 A write is accepted when w_en=1 and full=0; when full=1, a write is dropped and contents are unchanged.
REQ-015 A read is accepted when r_en=1 and empty=0; when empty=1, a read is ignored.
REQ-016 Simultaneous accepted read and write leave count unchanged.
- When full: the read is accepted, the write is dropped.
- When empty: the write is accepted, the read is ignored.
REQ-017 Write and read pointers wrap from DEPTH-1 to 0, with no power-of-two assumption.
REQ-018 count is registered and changes by at most ±1 per cycle.
- full = (count==DEPTH), empty = (count==0).
- almost_full and almost_empty are decoded from count.
REQ-019 FWFT=0: data_out is registered.
- Updates on the edge that accepts a read (1-cycle latency).
- Holds its value otherwise.
REQ-020 FWFT=1: data_out presents the head entry combinationally whenever empty=0.
- A read advances the head on the same edge.
- The first write into an empty FIFO is visible the cycle after it is accepted.
REQ-021 Data order is strictly FIFO across any number of pointer wraps.

Reset
REQ-022 While rst=1, the following hold:
- pointers=0, count=0, empty=1, full=0, almost_full=0, almost_empty=1;
- data_out=0;
- error flags=0.
REQ-023 Reset asserted mid-operation discards all contents; storage is not cleared.
REQ-024 After rst deasserts, the first edge accepts a write.

Configuration
REQ-025 Macro SFIFO_ERR_FLAGS_EN, when defined, adds sticky output ports overflow and underflow, 1 bit each.
- overflow sets the cycle after a write is dropped while full.
- underflow sets the cycle after a read is ignored while empty.
- Both clear only on rst.
REQ-026 Without SFIFO_ERR_FLAGS_EN, these ports and their logic are absent; all other behaviour is identical.

Structure
REQ-027 Package sfifo_pkg holds:
- mode constants SFIFO_STD=0 and SFIFO_FWFT=1;
- a count-width helper function.
REQ-028 Storage is one sub-module, sfifo_ram.
- Parameters WIDTH and DEPTH.
- One synchronous write port.
- One asynchronous read port.
- No reset.

Verification
REQ-029 Fill then drain (DEPTH=6, WIDTH=8, FWFT=0): write 6 words 0x01..0x06.
- full=1 after the 6th write; count=6.
- Read 6 times: data_out 0x01..0x06, each one cycle after its read.
- empty=1 at the end.
REQ-030 Overflow and underflow:
- Write 0xAA while full: dropped, contents intact; with SFIFO_ERR_FLAGS_EN, overflow=1 next cycle and stays 1.
- Read while empty: data_out holds; with SFIFO_ERR_FLAGS_EN, underflow=1.
REQ-031 Simultaneous read and write:
- At count=3: count stays 3 and data stays in order.
- At full: count goes 6->5, the write is dropped.
- At empty: count goes 0->1.
REQ-032 Wrap, non-power-of-two (DEPTH=6): stream 20 words 0x00..0x13 at a steady occupancy of 3; output order matches exactly.
REQ-033 FWFT=1: write 0x5C into an empty FIFO.
- Next cycle: empty=0 and data_out=0x5C with no read.
- A read then sets empty=1.
REQ-034 Mid-operation reset: with count=4, pulse rst asynchronously between edges.
- Immediately: count=0, empty=1, data_out=0.
- Next write 0x77 is the next word read.
